// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Desc     : Round-robin, packet-granular arbiter that merges NUM_SRC AXI-Stream
//            byte sources into one registered stream for uart_tx. A grant is
//            held until the source sends tlast or MAX_BURST bytes.
//            Optional macro UART_ARB_TIMEOUT_EN: when defined, a stalled
//            source loses its grant after TIMEOUT_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int MAX_BURST      = 256,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ID_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid,
  input  logic [8*NUM_SRC-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]     s_axis_tlast,
  output logic [NUM_SRC-1:0]     s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [ID_W-1:0]        m_axis_tid,
  input  logic                   m_axis_tready,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   timeout_evt
);

  // Counter wide enough to reach MAX_BURST without wrapping inside a grant.
  localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic [ID_W-1:0]      gidx_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [BURST_W-1:0]   burst_cnt_q;

  logic                 m_valid_q;
  logic [7:0]           m_data_q;
  logic                 m_last_q;
  logic [ID_W-1:0]      m_id_q;

  logic                 w_any_req;
  logic [ID_W-1:0]      w_pick_idx;
  logic [NUM_SRC-1:0]   w_pick_onehot;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [7:0]           w_sel_data;
  logic                 w_out_free;
  logic                 w_src_hs;
  logic [BURST_W-1:0]   w_burst_next;
  logic                 w_burst_hit;
  logic                 w_release;
  logic [ID_W-1:0]      w_rr_next;

  // Round-robin pick: scan from rr_ptr upward; the lowest offset with valid wins.
  always_comb begin
    logic [ID_W:0] v_sum;
    w_any_req  = 1'b0;
    w_pick_idx = '0;
    v_sum      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      v_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (v_sum >= (ID_W + 1)'(NUM_SRC)) begin
        v_sum = v_sum - (ID_W + 1)'(NUM_SRC);
      end
      if (s_axis_tvalid[v_sum[ID_W-1:0]]) begin
        w_any_req  = 1'b1;
        w_pick_idx = v_sum[ID_W-1:0];
      end
    end
    w_pick_onehot = NUM_SRC'(1) << w_pick_idx;
  end

  // Granted-source view and handshake / release decode.
  assign w_sel_valid  = s_axis_tvalid[gidx_q];
  assign w_sel_last   = s_axis_tlast[gidx_q];
  assign w_sel_data   = s_axis_tdata[{gidx_q, 3'b000} +: 8];
  assign w_out_free   = !m_valid_q || m_axis_tready;
  assign w_src_hs     = (state_q == ST_BUSY) && w_sel_valid && w_out_free;
  assign w_burst_next = burst_cnt_q + BURST_W'(1);
  assign w_burst_hit  = (MAX_BURST != 0) && (w_burst_next == BURST_W'(MAX_BURST));
  assign w_release    = w_src_hs && (w_sel_last || w_burst_hit);
  assign w_rr_next    = (gidx_q == ID_W'(NUM_SRC - 1)) ? '0 : gidx_q + ID_W'(1);

  // Ready depends only on registered state and m_axis_tready, never on tvalid.
  assign s_axis_tready = ((state_q == ST_BUSY) && w_out_free) ? grant_q : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] w_stall_next;
  logic               timeout_evt_q;
  assign w_stall_next = stall_cnt_q + STALL_W'(1);
  assign timeout_evt  = timeout_evt_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_evt      = 1'b0;
`endif

  // Arbitration FSM: grant issue, burst counting and packet/burst/timeout release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      timeout_evt_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_evt_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          burst_cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
          stall_cnt_q <= '0;
`endif
          if (w_any_req) begin
            state_q <= ST_BUSY;
            gidx_q  <= w_pick_idx;
            grant_q <= w_pick_onehot;
          end
        end
        ST_BUSY: begin
          if (w_src_hs) begin
            burst_cnt_q <= w_burst_next;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
            if (w_release) begin
              state_q  <= ST_IDLE;
              grant_q  <= '0;
              rr_ptr_q <= w_rr_next;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (!w_sel_valid) begin
            if (w_stall_next == STALL_W'(TIMEOUT_CYCLES)) begin
              state_q       <= ST_IDLE;
              grant_q       <= '0;
              rr_ptr_q      <= w_rr_next;
              timeout_evt_q <= 1'b1;
            end else begin
              stall_cnt_q <= w_stall_next;
            end
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Single-entry output register: load on source handshake, empty when drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else if (w_src_hs) begin
      m_valid_q <= 1'b1;
      m_data_q  <= w_sel_data;
      m_last_q  <= w_sel_last;
      m_id_q    <= gidx_q;
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_id_q;
  assign grant         = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Desc     : Self-checking bench for uart_tx_arbiter (NUM_SRC=4, MAX_BURST=4,
//            TIMEOUT_CYCLES=16). Expected output bytes are queued in arbitration
//            order by each test and compared as the DUT drains them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [8*NUM_SRC-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic                 m_axis_tvalid;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tlast;
  logic [ID_W-1:0]      m_axis_tid;
  logic                 m_axis_tready;
  logic [NUM_SRC-1:0]   grant;
  logic                 timeout_evt;

  uart_tx_arbiter #(
    .NUM_SRC(NUM_SRC), .MAX_BURST(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tready(m_axis_tready), .grant(grant), .timeout_evt(timeout_evt)
  );

  always #5 aclk = ~aclk;

  // Per-source byte FIFOs: {last, data}
  logic [8:0]  src_mem [NUM_SRC][64];
  int          src_head [NUM_SRC];
  int          src_tail [NUM_SRC];
  int          acc_cnt  [NUM_SRC];
  logic [10:0] sb [$];          // expected {tid, last, data}
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        m_rdy = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]  prev_d = '0;

  task automatic push_src(input int i, input logic last, input logic [7:0] d);
    src_mem[i][src_tail[i]] = {last, d};
    src_tail[i]++;
  endtask

  task automatic expect_out(input int tid, input logic last, input logic [7:0] d);
    sb.push_back({2'(tid), last, d});
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) if (src_head[i] != src_tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_head[i] = 0; src_tail[i] = 0;
    end
    sb.delete();
    prev_v = 1'b0; prev_r = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1 ns later, account for the handshakes
  // that the coming posedge will perform.
  task automatic step();
    logic [10:0] exp_w;
    @(negedge aclk);
    cyc++;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_head[i] != src_tail[i]) begin
        s_axis_tvalid[i]       = 1'b1;
        s_axis_tdata[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        s_axis_tlast[i]        = src_mem[i][src_head[i]][8];
      end else begin
        s_axis_tvalid[i]       = 1'b0;
        s_axis_tdata[8*i +: 8] = 8'h00;
        s_axis_tlast[i]        = 1'b0;
      end
    end
    m_axis_tready = m_rdy;
    #1;
    checks++;
    if ($countones(s_axis_tready) > 1 || (s_axis_tready & ~grant) != '0) begin
      errors++;
      $display("FAIL ready_onehot: cyc=%0d ready=%b grant=%b", cyc, s_axis_tready, grant);
    end
    if (prev_v && !prev_r) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                 cyc, m_axis_tvalid, m_axis_tdata, prev_d);
      end
    end
`ifndef UART_ARB_TIMEOUT_EN
    checks++;
    if (timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied: cyc=%0d got %b want 0", cyc, timeout_evt);
    end
`endif
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: cyc=%0d got tid=%0d last=%b data=%h want none",
                 cyc, m_axis_tid, m_axis_tlast, m_axis_tdata);
      end else begin
        exp_w = sb.pop_front();
        if ({m_axis_tid, m_axis_tlast, m_axis_tdata} !== exp_w) begin
          errors++;
          $display("FAIL out_byte: cyc=%0d got tid=%0d last=%b data=%h want tid=%0d last=%b data=%h",
                   cyc, m_axis_tid, m_axis_tlast, m_axis_tdata, exp_w[10:9], exp_w[8], exp_w[7:0]);
        end
      end
    end
    prev_v = m_axis_tvalid; prev_r = m_axis_tready; prev_d = m_axis_tdata;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        src_head[i]++;
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || src_pending()) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || src_pending()) begin
      errors++;
      $display("FAIL %s_drain: %0d output bytes outstanding, want 0", name, sb.size());
      clear_all();
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_all();
    step(); step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    m_rdy = 1'b0;
    aresetn = 1'b0;
    step(); step();
    checks++;
    if (grant !== 4'b0 || s_axis_tready !== 4'b0 || m_axis_tvalid !== 1'b0 ||
        m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 || m_axis_tid !== 2'd0 ||
        timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b rdy=%b v=%b d=%h l=%b id=%0d evt=%b want all 0",
               grant, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, timeout_evt);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    m_rdy = 1'b1;
    push_src(0, 1'b0, 8'h41); push_src(0, 1'b0, 8'h42); push_src(0, 1'b1, 8'h43);
    expect_out(0, 1'b0, 8'h41); expect_out(0, 1'b0, 8'h42); expect_out(0, 1'b1, 8'h43);
    step();
    checks++;
    if (grant !== 4'b0000 || s_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_grant: grant=%b ready=%b want 0000/0000", grant, s_axis_tready);
    end
    step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL grant_latency: grant=%b want 0001", grant);
    end
    wait_drain("single", 40);
    step();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL release_idle: grant=%b want 0000", grant);
    end
    // rr_ptr is now 1: src1 must beat src0
    push_src(0, 1'b1, 8'hE0); push_src(1, 1'b1, 8'hE1);
    expect_out(1, 1'b1, 8'hE1); expect_out(0, 1'b1, 8'hE0);
    wait_drain("rr_advance", 40);
  endtask

  task automatic test_round_robin();
    do_reset();
    m_rdy = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_src(i, 1'b0, 8'hA0 | 8'(i)); push_src(i, 1'b1, 8'hB0 | 8'(i));
      expect_out(i, 1'b0, 8'hA0 | 8'(i)); expect_out(i, 1'b1, 8'hB0 | 8'(i));
    end
    wait_drain("round_robin", 60);
  endtask

  task automatic test_backpressure();
    int base, n;
    m_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_src(2, (k == 3), 8'hC0 | 8'(k));
      expect_out(2, (k == 3), 8'hC0 | 8'(k));
    end
    n = 0;
    while (acc_cnt[2] == 0 && n < 20) begin step(); n++; end
    base = acc_cnt[2];
    m_rdy = 1'b0;
    repeat (10) step();
    checks++;
    if (acc_cnt[2] - base > 1) begin
      errors++;
      $display("FAIL stall_accept: accepted %0d during stall, want <=1", acc_cnt[2] - base);
    end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid: m_axis_tvalid=%b want 1", m_axis_tvalid);
    end
    m_rdy = 1'b1;
    wait_drain("backpressure", 40);
  endtask

  task automatic test_burst_limit();
    m_rdy = 1'b1;
    for (int k = 0; k < 10; k++) push_src(1, 1'b0, 8'h10 + 8'(k));
    step();
    push_src(3, 1'b0, 8'h30); push_src(3, 1'b1, 8'h31);
    for (int k = 0; k < 4; k++) expect_out(1, 1'b0, 8'h10 + 8'(k));
    expect_out(3, 1'b0, 8'h30); expect_out(3, 1'b1, 8'h31);
    for (int k = 4; k < 10; k++) expect_out(1, 1'b0, 8'h10 + 8'(k));
    wait_drain("burst", 80);
    step();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL burst_hold_grant: grant=%b want 0010", grant);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    m_rdy = 1'b0;
    push_src(1, 1'b0, 8'h55);
    while (m_axis_tvalid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: m_axis_tvalid=%b want 1", m_axis_tvalid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0 || s_axis_tready !== 4'b0 || m_axis_tvalid !== 1'b0 ||
        m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 || m_axis_tid !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b rdy=%b v=%b d=%h l=%b id=%0d want all 0",
               grant, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid);
    end
    clear_all();
    step(); step();
    aresetn = 1'b1;
    m_rdy = 1'b1;
    push_src(0, 1'b1, 8'h60); push_src(2, 1'b1, 8'h62);
    expect_out(0, 1'b1, 8'h60); expect_out(2, 1'b1, 8'h62);
    step(); step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rr_after_reset: grant=%b want 0001", grant);
    end
    wait_drain("post_reset", 40);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int hs_cyc;
    logic exp_evt;
    m_rdy = 1'b1;
    push_src(0, 1'b0, 8'h70);
    expect_out(0, 1'b0, 8'h70); expect_out(1, 1'b1, 8'h71);
    while (acc_cnt[0] == 0 && n < 20) begin step(); n++; end
    hs_cyc = cyc;
    push_src(1, 1'b1, 8'h71);
    repeat (17) begin
      step();
      exp_evt = (cyc == hs_cyc + 17);
      checks++;
      if (timeout_evt !== exp_evt) begin
        errors++;
        $display("FAIL timeout_evt: cyc=%0d got %b want %b", cyc - hs_cyc, timeout_evt, exp_evt);
      end
    end
    step();
    checks++;
    if (grant !== 4'b0010 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant: grant=%b evt=%b want 0010/0", grant, timeout_evt);
    end
    wait_drain("timeout", 40);
  endtask
`endif

  initial begin
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0; m_axis_tready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_head[i] = 0; src_tail[i] = 0; acc_cnt[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_burst_limit();
    test_async_reset();
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < NUM_SRC; i++) acc_cnt[i] = 0;
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin, packet-granular arbiter that shares one uart_tx byte stream between NUM_SRC AXI-Stream byte sources. It sits between the per-source FIFOs and the uart_tx s_axis input, so multi-byte messages from different sources never interleave on the wire. The output is registered, with a single-entry buffer. A burst limit stops any one source from holding the UART indefinitely.

Parameters:
NUM_SRC, 4, number of requesting sources (1..16)
MAX_BURST, 256, max bytes per grant before forced release; 0 = unlimited (release only on tlast)
TIMEOUT_CYCLES, 1_000_000, idle-stall cycles before forced release (used only with UART_ARB_TIMEOUT_EN)
ID_W, derived: NUM_SRC>1 ? $clog2(NUM_SRC) : 1

Ports:
aclk  in  1  single clock
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tdata  in  8*NUM_SRC  per-source byte; source i at [8i+7:8i]
s_axis_tlast  in  NUM_SRC  per-source end-of-message
s_axis_tready  out  NUM_SRC  per-source ready; at most one bit high
m_axis_tvalid  out  1  byte valid to uart_tx
m_axis_tdata  out  8  byte to uart_tx
m_axis_tlast  out  1  last byte of message
m_axis_tid  out  ID_W  source index of current output byte
m_axis_tready  in  1  uart_tx ready
grant  out  NUM_SRC  one-hot current grant; 0 when IDLE
timeout_evt  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant=0, s_axis_tready=0, m_axis_tvalid=0, tdata/tlast/tid=0, burst_cnt=0, timeout_evt=0.
- States: IDLE, BUSY.
- IDLE
  - Pick the first i with s_axis_tvalid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - Next cycle: BUSY, grant=onehot(i), burst_cnt=0.
  - Arbitration latency is 1 cycle. No s_axis_tready is asserted in IDLE.
- BUSY
  - s_axis_tready[g] = !m_axis_tvalid || m_axis_tready. All other ready bits are 0.
  - Source handshake (valid&ready on g): output register loads tdata/tlast/tid=g, m_axis_tvalid=1, burst_cnt++.
  - Output handshake with no new load: m_axis_tvalid=0.
  - Simultaneous load and drain: register reloads and stays valid. Full throughput is 1 byte/cycle.
- Release
  - Release condition: source handshake with s_axis_tlast[g]=1, OR (MAX_BURST!=0 and burst_cnt reaches MAX_BURST on that handshake).
  - On release: next state IDLE, grant=0, rr_ptr=(g+1) mod NUM_SRC.
  - A forced burst release does not set m_axis_tlast. m_axis_tlast mirrors the source tlast only.
  - The output register may still hold the final byte after release; it drains independently.
  - A new grant may be issued while that byte is pending. The new source's ready waits on the same register rule.
- Grant is fixed for the whole BUSY period. Source tvalid deasserting mid-message does not release the grant.
- NUM_SRC=1: the arbiter degenerates to a registered pass-through with IDLE/BUSY sequencing. tid=0.
- burst_cnt is sized to hold MAX_BURST. It never wraps inside a grant, because release occurs at MAX_BURST.
- No combinational path from s_axis_tvalid to s_axis_tready, or from m_axis_tready to m_axis_tvalid.
- The m_axis_tready→s_axis_tready path is combinational, which is acceptable.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter runs in BUSY while s_axis_tvalid[g]=0 and clears on any source handshake.
  - When it reaches TIMEOUT_CYCLES: release exactly as on tlast (IDLE, rr_ptr=g+1) and pulse timeout_evt for 1 cycle.
  - The output register is untouched.
- Undefined: no stall counter; timeout_evt is tied 0; a stalled source holds the grant indefinitely.

Test Plan:
1. NUM_SRC=4. Src0 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43); m_axis_tready=1 → output 41,42,43 with tid=0, tlast only on 43. grant=0001 one cycle after tvalid. Back to IDLE, rr_ptr=1.
2. All 4 sources valid with 2-byte messages {0xA0|i, 0xB0|i} → output order src0,src1,src2,src3. No interleaving; exactly one s_axis_tready bit high at any time.
3. m_axis_tready held low 10 cycles mid-message from src2 → at most 1 byte accepted from src2; m_axis_tvalid and tdata stable throughout. Resumes without loss or duplication when ready returns.
4. MAX_BURST=4; src1 streams 10 bytes with no tlast while src3 is valid → src1 bytes 0–3, src3's message, then src1 bytes 4–7. tlast=0 on all forced-release bytes.
5. aresetn asserted while BUSY with m_axis_tvalid=1 → same cycle all outputs 0, grant=0. After release, src0 wins first.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: src0 sends 1 byte without tlast, then idles while src1 is valid → timeout_evt pulses 16 cycles after the last handshake. src1 is granted the next cycle.
